// File: rtl/pong_game_ctrl_if.sv
// Pong game controller bus: start button, scan position, draw strobes and
// game status outputs. The controller uses the slave modport and the
// surrounding video pipeline (or a bench) uses the master modport.
interface pong_game_ctrl_if;
    logic       i_start;
    logic [5:0] i_col;
    logic [5:0] i_row;
    logic       i_ball_draw;
    logic       i_paddle1_draw;
    logic       i_paddle2_draw;
    logic       o_game_active;
    logic [3:0] o_p1_score;
    logic [3:0] o_p2_score;
    logic       o_game_over;

    modport master (
        output i_start, i_col, i_row, i_ball_draw, i_paddle1_draw, i_paddle2_draw,
        input  o_game_active, o_p1_score, o_p2_score, o_game_over
    );

    modport slave (
        input  i_start, i_col, i_row, i_ball_draw, i_paddle1_draw, i_paddle2_draw,
        output o_game_active, o_p1_score, o_p2_score, o_game_over
    );
endinterface

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: game-level sequencer for Pong. Detects missed balls at
// either goal line from the per-tile draw strobes, keeps both scores and
// runs IDLE -> RUNNING -> POINT / GAME_OVER from a single start button.
// Optional macro PONG_SERVE_TIMER_EN: POINT re-serves automatically after
// SERVE_FRAMES frame wraps (a start edge still serves immediately).
module pong_game_ctrl #(
    parameter int GAME_WIDTH   = 40,
    parameter int GAME_HEIGHT  = 30,
    parameter int SCORE_LIMIT  = 9,
    parameter int SERVE_FRAMES = 60
) (
    input logic              i_clk,
    input logic              i_rst_n,
    pong_game_ctrl_if.slave  bus
);

    // Elaboration-time guard on parameter ranges.
    if (SCORE_LIMIT < 1 || SCORE_LIMIT > 15 || GAME_HEIGHT < 1 || GAME_HEIGHT > 64 ||
        GAME_WIDTH < 3 || GAME_WIDTH > 64 || SERVE_FRAMES < 1) begin : g_param_check
        $error("pong_game_ctrl: parameter out of range");
    end

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUNNING   = 2'd1,
        ST_POINT     = 2'd2,
        ST_GAME_OVER = 2'd3
    } state_t;

    localparam logic [5:0] COL_BALL_L = 6'd1;
    localparam logic [5:0] COL_PAD_L  = 6'd0;
    localparam logic [5:0] COL_BALL_R = 6'(GAME_WIDTH - 2);
    localparam logic [5:0] COL_PAD_R  = 6'(GAME_WIDTH - 1);
    localparam logic [3:0] LIMIT      = 4'(SCORE_LIMIT);

    state_t     state_q, state_d;
    logic [5:0] d_col_q, d_row_q, d_row_prev_q;
    logic       start_q, start_prev_q;
    logic       ball_l_q, pad_l_q, ball_r_q, pad_r_q;
    logic       ball_l_d, pad_l_d, ball_r_d, pad_r_d;
    logic [3:0] p1_q, p1_d, p2_q, p2_d;
    logic       active_q, active_d, over_q, over_d;

    logic       start_edge;
    logic       row_bnd;
    logic       miss_l, miss_r;

    assign start_edge = start_q & ~start_prev_q;
    // Strobes lag the scan position by one clock, so compare against the
    // registered column/row.
    assign row_bnd    = (d_row_q != d_row_prev_q);
    assign miss_l     = ball_l_q & ~pad_l_q;
    assign miss_r     = ball_r_q & ~pad_r_q;

`ifdef PONG_SERVE_TIMER_EN
    localparam int              CNT_W    = $clog2(SERVE_FRAMES + 1);
    localparam logic [CNT_W-1:0] SRV_LAST = CNT_W'(SERVE_FRAMES - 1);

    logic [CNT_W-1:0] srv_cnt_q, srv_cnt_d;
    logic             frame;

    assign frame = (d_row_q == 6'd0) && (d_row_prev_q != 6'd0);
`endif

    // Next-state, score, flag and output computation.
    always_comb begin
        state_d = state_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
`ifdef PONG_SERVE_TIMER_EN
        srv_cnt_d = (state_q == ST_POINT) ? srv_cnt_q : '0;
`endif
        case (state_q)
            ST_IDLE: begin
                p1_d = 4'd0;
                p2_d = 4'd0;
                if (start_edge) state_d = ST_RUNNING;
            end
            ST_RUNNING: begin
                // Left miss takes priority when both goals miss in one row.
                if (row_bnd && miss_l) begin
                    p2_d    = p2_q + 4'd1;
                    state_d = (p2_q + 4'd1 == LIMIT) ? ST_GAME_OVER : ST_POINT;
                end else if (row_bnd && miss_r) begin
                    p1_d    = p1_q + 4'd1;
                    state_d = (p1_q + 4'd1 == LIMIT) ? ST_GAME_OVER : ST_POINT;
                end
            end
            ST_POINT: begin
                if (start_edge) begin
                    state_d = ST_RUNNING;
                end
`ifdef PONG_SERVE_TIMER_EN
                else if (frame) begin
                    if (srv_cnt_q == SRV_LAST) begin
                        state_d   = ST_RUNNING;
                        srv_cnt_d = '0;
                    end else begin
                        srv_cnt_d = srv_cnt_q + 1'b1;
                    end
                end
`endif
            end
            default: begin
                if (start_edge) begin
                    p1_d    = 4'd0;
                    p2_d    = 4'd0;
                    state_d = ST_RUNNING;
                end
            end
        endcase

        // Flags only accumulate inside a running row; a strobe landing on a
        // row-boundary cycle belongs to the new row's column 0 and is dropped.
        if (state_q != ST_RUNNING || state_d != ST_RUNNING || row_bnd) begin
            ball_l_d = 1'b0;
            pad_l_d  = 1'b0;
            ball_r_d = 1'b0;
            pad_r_d  = 1'b0;
        end else begin
            ball_l_d = ball_l_q | ((d_col_q == COL_BALL_L) & bus.i_ball_draw);
            pad_l_d  = pad_l_q  | ((d_col_q == COL_PAD_L)  & bus.i_paddle1_draw);
            ball_r_d = ball_r_q | ((d_col_q == COL_BALL_R) & bus.i_ball_draw);
            pad_r_d  = pad_r_q  | ((d_col_q == COL_PAD_R)  & bus.i_paddle2_draw);
        end

        active_d = (state_d == ST_RUNNING);
        over_d   = (state_d == ST_GAME_OVER);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            d_col_q      <= 6'd0;
            d_row_q      <= 6'd0;
            d_row_prev_q <= 6'd0;
            start_q      <= 1'b0;
            start_prev_q <= 1'b0;
            ball_l_q     <= 1'b0;
            pad_l_q      <= 1'b0;
            ball_r_q     <= 1'b0;
            pad_r_q      <= 1'b0;
            p1_q         <= 4'd0;
            p2_q         <= 4'd0;
            active_q     <= 1'b0;
            over_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            d_col_q      <= bus.i_col;
            d_row_q      <= bus.i_row;
            d_row_prev_q <= d_row_q;
            start_q      <= bus.i_start;
            start_prev_q <= start_q;
            ball_l_q     <= ball_l_d;
            pad_l_q      <= pad_l_d;
            ball_r_q     <= ball_r_d;
            pad_r_q      <= pad_r_d;
            p1_q         <= p1_d;
            p2_q         <= p2_d;
            active_q     <= active_d;
            over_q       <= over_d;
        end
    end

`ifdef PONG_SERVE_TIMER_EN
    // Frame counter for the automatic re-serve.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) srv_cnt_q <= '0;
        else          srv_cnt_q <= srv_cnt_d;
    end
`endif

    assign bus.o_game_active = active_q;
    assign bus.o_game_over   = over_q;
    assign bus.o_p1_score    = p1_q;
    assign bus.o_p2_score    = p2_q;

endmodule
